serial_pattern_detector: RTL and testbench

Serial-input pattern detector that consumes the registered single-bit stream produced by the lab's D flip-flop stage (its `Q` drives this block's `D`). It shifts accepted bits into a PAT_LEN-bit window and flags each occurrence of a parameterised bit pattern. Overlapping or non-overlapping detection is selected by parameter. It keeps a saturating count of matches for display or checking downstream.

---
 rtl/dsd_pkg.sv | 14 +
 rtl/sipo_shift_reg.sv | 21 ++
 rtl/serial_pattern_detector.sv | 81 ++++++++
 tb/tb_serial_pattern_detector.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/dsd_pkg.sv
// Shared definitions for the serial pattern detector block.
package dsd_pkg;

  // Default pattern length and the pattern used when none is given
  localparam int unsigned PAT_LEN_DEF = 4;
  localparam logic [3:0]  PAT_1011    = 4'b1011;

  // Fill-tracking FSM: FILL until PAT_LEN fresh bits are held, then ARMED
  typedef enum logic {
    FILL,
    ARMED
  } fsm_state_e;

endpackage

// File: rtl/sipo_shift_reg.sv
// Serial-in parallel-out shift register; the newest bit enters at the LSB.
module sipo_shift_reg #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             D,
  output logic [WIDTH-1:0] Q
);

  // Shift one bit in per enabled edge; synchronous reset clears the window
  always_ff @(posedge clock) begin
    if (reset) begin
      Q <= '0;
    end else if (en) begin
      Q <= {Q[WIDTH-2:0], D};
    end
  end

endmodule

// File: rtl/serial_pattern_detector.sv
// Serial pattern detector: shifts accepted bits into a window, pulses on a
// pattern match and keeps a saturating match count.
module serial_pattern_detector
  import dsd_pkg::*;
#(
  parameter int unsigned         PAT_LEN = PAT_LEN_DEF,
  parameter logic [PAT_LEN-1:0]  PATTERN = PAT_LEN'(PAT_1011),
  parameter bit                  OVERLAP = 1'b1,
  parameter int unsigned         CNT_W   = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               D,
  input  logic               valid,
  output logic               detect,
  output logic [CNT_W-1:0]   match_count,
  output logic [PAT_LEN-1:0] window,
  output logic               armed
);

  localparam int unsigned        FILL_W    = $clog2(PAT_LEN + 1);
  localparam logic [FILL_W-1:0]  FILL_FULL = FILL_W'(PAT_LEN);
  localparam logic [CNT_W-1:0]   CNT_MAX   = '1;

  fsm_state_e          state_q;
  logic [FILL_W-1:0]   fill_q;
  logic [FILL_W-1:0]   fill_d;
  logic                detect_q;
  logic [CNT_W-1:0]    count_q;
  logic [PAT_LEN-1:0]  win_nxt;
  logic                hit;

  sipo_shift_reg #(
    .WIDTH (PAT_LEN)
  ) u_window (
    .clock (clock),
    .reset (reset),
    .en    (valid),
    .D     (D),
    .Q     (window)
  );

  // Next-state window/fill and the match decision for this edge
  always_comb begin
    win_nxt = {window[PAT_LEN-2:0], D};
    fill_d  = fill_q;
    if (valid && (fill_q != FILL_FULL)) begin
      fill_d = fill_q + FILL_W'(1);
    end
    // Fill gating keeps the all-zero reset window from matching an all-zero pattern
    hit = valid && (win_nxt == PATTERN) && (fill_d == FILL_FULL);
  end

  // FSM, fill counter, detect pulse and saturating match counter
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= FILL;
      fill_q   <= '0;
      detect_q <= 1'b0;
      count_q  <= '0;
    end else begin
      detect_q <= hit;
      if (hit && (count_q != CNT_MAX)) begin
        count_q <= count_q + CNT_W'(1);
      end
      if (hit && !OVERLAP) begin
        // Non-overlapping: demand PAT_LEN fresh bits before the next match
        fill_q  <= '0;
        state_q <= FILL;
      end else begin
        fill_q  <= fill_d;
        state_q <= (fill_d == FILL_FULL) ? ARMED : FILL;
      end
    end
  end

  assign detect      = detect_q;
  assign match_count = count_q;
  assign armed       = (state_q == ARMED);

endmodule

// File: tb/tb_serial_pattern_detector.sv
// Self-checking bench for serial_pattern_detector using four configurations.
module tb_serial_pattern_detector;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] d_r   = '0;
  logic [3:0] v_r   = '0;

  logic [3:0] det_w;
  logic [3:0] arm_w;
  logic [3:0] win_w [4];
  logic [7:0] cnt_w [4];
  logic [1:0] cnt_sat;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int unsigned inst;
    logic        det;
    logic [7:0]  cnt;
    logic        arm;
    logic [3:0]  win;
  } exp_t;

  exp_t sb[$];

  always #5 clock = ~clock;

  assign cnt_w[2] = {6'b0, cnt_sat};

  // inst 0: overlapping, 8-bit counter
  serial_pattern_detector #(
    .PAT_LEN (4), .PATTERN (4'b1011), .OVERLAP (1'b1), .CNT_W (8)
  ) u_ov (
    .clock (clock), .reset (reset), .D (d_r[0]), .valid (v_r[0]),
    .detect (det_w[0]), .match_count (cnt_w[0]), .window (win_w[0]), .armed (arm_w[0])
  );

  // inst 1: non-overlapping
  serial_pattern_detector #(
    .PAT_LEN (4), .PATTERN (4'b1011), .OVERLAP (1'b0), .CNT_W (8)
  ) u_nov (
    .clock (clock), .reset (reset), .D (d_r[1]), .valid (v_r[1]),
    .detect (det_w[1]), .match_count (cnt_w[1]), .window (win_w[1]), .armed (arm_w[1])
  );

  // inst 2: 2-bit saturating counter
  serial_pattern_detector #(
    .PAT_LEN (4), .PATTERN (4'b1011), .OVERLAP (1'b1), .CNT_W (2)
  ) u_sat (
    .clock (clock), .reset (reset), .D (d_r[2]), .valid (v_r[2]),
    .detect (det_w[2]), .match_count (cnt_sat), .window (win_w[2]), .armed (arm_w[2])
  );

  // inst 3: all-zero pattern
  serial_pattern_detector #(
    .PAT_LEN (4), .PATTERN (4'b0000), .OVERLAP (1'b1), .CNT_W (8)
  ) u_zero (
    .clock (clock), .reset (reset), .D (d_r[3]), .valid (v_r[3]),
    .detect (det_w[3]), .match_count (cnt_w[3]), .window (win_w[3]), .armed (arm_w[3])
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Drive one edge on one instance (others idle), queue expectation, compare after edge
  task automatic step(input int unsigned inst, input logic rst, input logic vld, input logic d,
                      input logic det, input logic [7:0] cnt, input logic arm,
                      input logic [3:0] win, input string tag);
    exp_t e;
    @(negedge clock);
    reset     = rst;
    d_r       = '0;
    v_r       = '0;
    d_r[inst] = d;
    v_r[inst] = vld;
    e = '{inst: inst, det: det, cnt: cnt, arm: arm, win: win};
    sb.push_back(e);
    @(posedge clock);
    #1;
    e = sb.pop_front();
    check_eq({tag, ".det"}, 32'(det_w[e.inst]), 32'(e.det));
    check_eq({tag, ".cnt"}, 32'(cnt_w[e.inst]), 32'(e.cnt));
    check_eq({tag, ".arm"}, 32'(arm_w[e.inst]), 32'(e.arm));
    check_eq({tag, ".win"}, 32'(win_w[e.inst]), 32'(e.win));
  endtask

  initial begin
    logic [3:0] pat;
    logic [3:0] shadow;
    logic [7:0] cnt;
    logic       b;
    logic       det;

    // Reset state of every instance
    step(0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 4'b0000, "rst");
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("rst%0d.det", i), 32'(det_w[i]), 32'd0);
      check_eq($sformatf("rst%0d.cnt", i), 32'(cnt_w[i]), 32'd0);
      check_eq($sformatf("rst%0d.arm", i), 32'(arm_w[i]), 32'd0);
      check_eq($sformatf("rst%0d.win", i), 32'(win_w[i]), 32'd0);
    end

    // Overlapping: stream 1,0,1,1,0,1,1
    step(0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 4'b0001, "ovA1");
    step(0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 4'b0010, "ovA2");
    step(0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 4'b0101, "ovA3");
    step(0, 1'b0, 1'b1, 1'b1, 1'b1, 8'd1, 1'b1, 4'b1011, "ovA4");
    step(0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 1'b1, 4'b0110, "ovA5");
    step(0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd1, 1'b1, 4'b1101, "ovA6");
    step(0, 1'b0, 1'b1, 1'b1, 1'b1, 8'd2, 1'b1, 4'b1011, "ovA7");

    // Non-overlapping: same stream, then one more bit re-arms (fill was 3)
    step(1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 4'b0000, "novR");
    step(1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 4'b0001, "novB1");
    step(1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 4'b0010, "novB2");
    step(1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 4'b0101, "novB3");
    step(1, 1'b0, 1'b1, 1'b1, 1'b1, 8'd1, 1'b0, 4'b1011, "novB4");
    step(1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 1'b0, 4'b0110, "novB5");
    step(1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd1, 1'b0, 4'b1101, "novB6");
    step(1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd1, 1'b0, 4'b1011, "novB7");
    step(1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 1'b1, 4'b0110, "novB8");

    // Valid gaps
    step(0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 4'b0000, "gapR");
    step(0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 4'b0001, "gapC1");
    step(0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 4'b0010, "gapC2");
    step(0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 4'b0010, "gapIdle");
    step(0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 4'b0101, "gapC3");
    step(0, 1'b0, 1'b1, 1'b1, 1'b1, 8'd1, 1'b1, 4'b1011, "gapC4");
    step(0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1, 1'b1, 4'b1011, "gapHold");

    // Reset mid-stream; reset edge ignores valid/D
    step(0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 4'b0000, "midR0");
    step(0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 4'b0001, "midD1");
    step(0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 4'b0010, "midD2");
    step(0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 4'b0101, "midD3");
    step(0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 4'b0000, "midRst");
    step(0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 4'b0001, "midD4");

    // Saturation with a 2-bit counter: 1011 repeated four times
    step(2, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 4'b0000, "satR");
    pat    = 4'b1011;
    shadow = '0;
    cnt    = '0;
    for (int i = 0; i < 16; i++) begin
      b      = pat[3 - (i % 4)];
      shadow = {shadow[2:0], b};
      det    = ((i % 4) == 3);
      if (det && (cnt < 8'd3)) cnt = cnt + 8'd1;
      step(2, 1'b0, 1'b1, b, det, cnt, (i >= 3), shadow, $sformatf("sat%0d", i));
    end

    // All-zero pattern must wait for four accepted zeros, then pulses back to back
    step(3, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 4'b0000, "zR");
    step(3, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 4'b0000, "z1");
    step(3, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 4'b0000, "z2");
    step(3, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 4'b0000, "z3");
    step(3, 1'b0, 1'b1, 1'b0, 1'b1, 8'd1, 1'b1, 4'b0000, "z4");
    step(3, 1'b0, 1'b1, 1'b0, 1'b1, 8'd2, 1'b1, 4'b0000, "z5");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
